// File: rtl/mcm_tpose_fir2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mcm_pkg
// Purpose  : Shared constants, widths and helpers for consumers of the 8-bit
//            DSP-based MCM block (products X*5748 and X*87, 1-clk latency).
// Revision : 1.0 - initial release
// ============================================================================
package mcm_pkg;

    // Multiplier constants and pipeline latency of the MCM block
    localparam int K_A    = 5748;
    localparam int K_B    = 87;
    localparam int MB_LAT = 1;

    // Datapath widths
    localparam int X_W   = 8;   // MCM input sample width
    localparam int PA_W  = 21;  // width of X*K_A
    localparam int PB_W  = 15;  // width of X*K_B
    localparam int ACC_W = 23;  // tap accumulator width

    // Sign-extend a product-width value to the accumulator width.
    function automatic logic signed [ACC_W-1:0] sext_acc(input logic signed [PA_W-1:0] v);
        return {{(ACC_W-PA_W){v[PA_W-1]}}, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mcm_tpose_fir2_if.sv
`default_nettype none
// ============================================================================
// Module   : mcm_tpose_fir2_if
// Purpose  : Bus between the MCM product source / sample sink and the
//            2-tap transposed FIR.
//   master : drives x_valid, p5748, p87, clear; receives y, y_valid,
//            sample_cnt, sat_flag
//   slave  : the filter side (opposite directions)
// Revision : 1.0 - initial release
// ============================================================================
interface mcm_tpose_fir2_if #(
    parameter int OUT_W = 22,
    parameter int CNT_W = 16
);
    import mcm_pkg::*;

    logic                    x_valid;
    logic signed [PA_W-1:0]  p5748;
    logic signed [PB_W-1:0]  p87;
    logic                    clear;
    logic signed [OUT_W-1:0] y;
    logic                    y_valid;
    logic [CNT_W-1:0]        sample_cnt;
    logic                    sat_flag;

    modport master (
        output x_valid, p5748, p87, clear,
        input  y, y_valid, sample_cnt, sat_flag
    );

    modport slave (
        input  x_valid, p5748, p87, clear,
        output y, y_valid, sample_cnt, sat_flag
    );

endinterface
`default_nettype wire

// File: rtl/mcm_tpose_fir2_round_sat.sv
`default_nettype none
// ============================================================================
// Module   : mcm_round_sat
// Purpose  : Combinational round-half-up right shift followed by signed
//            saturation to OUT_W bits.
//   acc_in  : signed IN_W input
//   y_out   : signed OUT_W rounded/saturated result
//   sat_out : high when the result was clamped
// Requires OUT_W <= IN_W + 1.
// Revision : 1.0 - initial release
// ============================================================================
module mcm_round_sat #(
    parameter int IN_W  = 23,
    parameter int OUT_W = 22,
    parameter int SHIFT = 0
) (
    input  wire logic signed [IN_W-1:0]  acc_in,
    output logic signed [OUT_W-1:0]      y_out,
    output logic                         sat_out
);

    // One guard bit so the rounding increment can never wrap.
    localparam int W = IN_W + 1;

    localparam logic signed [W-1:0] c_max = {{(W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [W-1:0] c_min = {{(W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [W-1:0] w_ext;
    logic signed [W-1:0] w_shifted;

    assign w_ext = {acc_in[IN_W-1], acc_in};

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [W-1:0] c_half = W'(1) << (SHIFT - 1);
            logic signed [W-1:0] w_sum;
            // Adding half an LSB then flooring gives round-half-toward-+inf.
            assign w_sum     = w_ext + c_half;
            assign w_shifted = w_sum >>> SHIFT;
        end else begin : g_pass
            assign w_shifted = w_ext;
        end
    endgenerate

    always_comb begin
        y_out   = w_shifted[OUT_W-1:0];
        sat_out = 1'b0;
        if (w_shifted > c_max) begin
            y_out   = c_max[OUT_W-1:0];
            sat_out = 1'b1;
        end else if (w_shifted < c_min) begin
            y_out   = c_min[OUT_W-1:0];
            sat_out = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mcm_tpose_fir2.sv
`default_nettype none
// ============================================================================
// Module   : mcm_tpose_fir2
// Purpose  : 2-tap transposed-form FIR y[n] = 5748*x[n] + 87*x[n-1] built
//            from MCM products, with optional rounding shift, saturation,
//            registered output strobe, sample counter and sticky sat flag.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : slave modport - x_valid, p5748, p87, clear in;
//           y, y_valid, sample_cnt, sat_flag out
// Revision : 1.0 - initial release
// ============================================================================
module mcm_tpose_fir2
    import mcm_pkg::*;
#(
    parameter int OUT_W = 22,
    parameter int SHIFT = 0,
    parameter int CNT_W = 16
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    mcm_tpose_fir2_if.slave    bus
);

    logic                     r_v_d;      // x_valid delayed by the MCM latency
    logic signed [ACC_W-1:0]  r_tap;      // transposed-form state: 87*x[n-1]
    logic signed [OUT_W-1:0]  r_y;
    logic                     r_y_valid;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_sat;

    logic signed [PA_W-1:0]   w_p87_ext;
    logic signed [ACC_W-1:0]  w_acc;
    logic signed [OUT_W-1:0]  w_y;
    logic                     w_sat;

    assign w_p87_ext = {{(PA_W-PB_W){bus.p87[PB_W-1]}}, bus.p87};
    assign w_acc     = sext_acc(bus.p5748) + r_tap;

    mcm_round_sat #(
        .IN_W  (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .acc_in  (w_acc),
        .y_out   (w_y),
        .sat_out (w_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v_d     <= 1'b0;
            r_tap     <= '0;
            r_y       <= '0;
            r_y_valid <= 1'b0;
            r_cnt     <= '0;
            r_sat     <= 1'b0;
        end else begin
            r_v_d <= bus.x_valid;
            if (bus.clear) begin
                // Flush wins over a coincident sample; y keeps its last value.
                r_tap     <= '0;
                r_y_valid <= 1'b0;
                r_cnt     <= '0;
                r_sat     <= 1'b0;
            end else if (r_v_d) begin
                // Tap advances only on valid samples, so gaps do not age x[n-1].
                r_tap     <= sext_acc(w_p87_ext);
                r_y       <= w_y;
                r_y_valid <= 1'b1;
                r_cnt     <= r_cnt + CNT_W'(1);
                if (w_sat) begin
                    r_sat <= 1'b1;
                end
            end else begin
                r_y_valid <= 1'b0;
            end
        end
    end

    assign bus.y          = r_y;
    assign bus.y_valid    = r_y_valid;
    assign bus.sample_cnt = r_cnt;
    assign bus.sat_flag   = r_sat;

endmodule
`default_nettype wire
